// File: rtl/frame_transfer_streamer_if.sv
// Pixel stream bundle between the frame streamer and the host link.
//   data  : pixel value (m_data)
//   valid : data holds a beat (m_valid)
//   ready : sink accepts the beat this cycle (m_ready)
//   last  : final beat of the frame (m_last)
// master drives data/valid/last; slave drives ready.
interface frame_transfer_streamer_if #(
   parameter int PIX_W = 8
);
   logic [PIX_W-1:0] data;
   logic             valid;
   logic             ready;
   logic             last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/frame_transfer_streamer.sv
// frame_transfer_streamer
// Reads the finished output frame from BRAM in raster order and streams it
// as valid/ready pixel beats, then pulses transfer_done for the control FSM.
// A 2-entry prefetch FIFO hides the one-cycle BRAM read latency so a full
// frame moves at one pixel per cycle while the sink is ready.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a frame (only honoured in IDLE)
//   bram_en        : BRAM read enable
//   bram_addr      : BRAM read address (row*COLS+col)
//   bram_dout      : BRAM read data, valid the cycle after bram_en
//   m              : pixel stream (master modport)
//   busy           : high whenever not IDLE
//   transfer_done  : one-cycle pulse after the final beat is accepted
//
// Optional build macro TRANSFER_CHECKSUM_EN: appends one beat carrying the
// sum of all pixels modulo 2^PIX_W; m.last and transfer_done move to it.
//
// state  | meaning
// IDLE   | waiting for start, all outputs low
// STREAM | issuing reads while FIFO + in-flight has room, emitting beats
// DRAIN  | all reads issued, emitting remaining beats
// DONE   | transfer_done pulse, back to IDLE
module frame_transfer_streamer #(
   parameter int ROWS   = 240,
   parameter int COLS   = 320,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 17
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic                       bram_en,
   output logic [ADDR_W-1:0]          bram_addr,
   input  logic [PIX_W-1:0]           bram_dout,
   frame_transfer_streamer_if.master  m,
   output logic                       busy,
   output logic                       transfer_done
);

   localparam int NPIX = ROWS * COLS;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_W-1:0] rd_cnt;
   logic [ADDR_W-1:0] sent_cnt;
   logic              in_flight;
   logic [PIX_W-1:0]  fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_cnt;

   logic              load;
   logic              rd_go;
   logic              push;
   logic              pop;
   logic              fifo_beat;
   logic              beat_fire;
   logic              last_beat;
   logic [2:0]        occ_after;

   assign load      = (state == IDLE) && start;
   assign push      = in_flight;
   assign fifo_beat = (fifo_cnt != 2'd0);
   assign pop       = fifo_beat && m.ready;

   // Slots committed after this edge: the beat leaving this cycle frees its
   // slot, so a read can issue alongside it and keep one pixel per cycle.
   assign occ_after = {1'b0, fifo_cnt} + {2'b0, in_flight} - {2'b0, pop};
   assign rd_go     = (state == STREAM) && (occ_after < 3'd2);

   assign bram_en   = rd_go;
   assign bram_addr = rd_go ? rd_cnt : '0;

`ifdef TRANSFER_CHECKSUM_EN
   logic [PIX_W-1:0] cks_acc;
   logic             cks_beat;

   // Every pixel beat has left once sent_cnt reaches NPIX; only DRAIN can
   // see that, so the checksum beat follows the final pixel directly.
   assign cks_beat  = (state == DRAIN) && (sent_cnt == ADDR_W'(NPIX));
   assign m.valid   = fifo_beat || cks_beat;
   assign m.data    = fifo_beat ? fifo_mem[rd_ptr] : (cks_beat ? cks_acc : '0);
   assign last_beat = cks_beat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cks_acc <= '0;
      end else if (load) begin
         cks_acc <= '0;
      end else if (push) begin
         cks_acc <= cks_acc + bram_dout;
      end
   end
`else
   assign m.valid   = fifo_beat;
   assign m.data    = fifo_beat ? fifo_mem[rd_ptr] : '0;
   assign last_beat = fifo_beat && (sent_cnt == LAST_ADDR);
`endif

   assign m.last        = last_beat;
   assign beat_fire     = m.valid && m.ready;
   assign busy          = (state != IDLE);
   assign transfer_done = (state == DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = STREAM;
         STREAM:  if (rd_go && (rd_cnt == LAST_ADDR)) state_nxt = DRAIN;
         DRAIN:   if (beat_fire && last_beat) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt    <= '0;
         sent_cnt  <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= rd_go;
         if (load) begin
            rd_cnt   <= '0;
            sent_cnt <= '0;
         end else begin
            if (rd_go)     rd_cnt   <= rd_cnt + ADDR_W'(1);
            if (beat_fire) sent_cnt <= sent_cnt + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_cnt    <= 2'd0;
      end else if (load) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= bram_dout;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_frame_transfer_streamer.sv
module tb_frame_transfer_streamer;
   localparam int ROWS   = 4;
   localparam int COLS   = 6;
   localparam int PIX_W  = 8;
   localparam int ADDR_W = 5;
   localparam int N      = ROWS * COLS;
`ifdef TRANSFER_CHECKSUM_EN
   localparam bit CKS = 1'b1;
   localparam int NB  = N + 1;
`else
   localparam bit CKS = 1'b0;
   localparam int NB  = N;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              bram_en;
   logic [ADDR_W-1:0] bram_addr;
   logic [PIX_W-1:0]  bram_dout = '0;
   logic              busy;
   logic              transfer_done;

   frame_transfer_streamer_if #(.PIX_W(PIX_W)) m_if ();

   frame_transfer_streamer #(
      .ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .bram_en       (bram_en),
      .bram_addr     (bram_addr),
      .bram_dout     (bram_dout),
      .m             (m_if),
      .busy          (busy),
      .transfer_done (transfer_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } beat_t;

   beat_t exp_q[$];
   int n_chk = 0;
   int n_pass = 0;
   int pat_sel = 0;
   int rdy_mode = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int beats = 0;
   int reads = 0;

   function automatic logic [7:0] pix(int p, int a);
      int v;
      case (p)
         0:       v = a * 7 + 3;
         1:       v = a * 13 + 100;
         default: v = 1;
      endcase
      return v[7:0];
   endfunction

   task automatic check(string name, int act, int expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
   endtask

   // Cycle counter, BRAM model (one-cycle read latency) and ready driver.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      if (bram_en) bram_dout <= pix(pat_sel, int'(bram_addr));
   end

   initial begin
      m_if.ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_if.ready = 1'b1;
            1:       m_if.ready = ($urandom_range(0, 1) == 1);
            default: m_if.ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every accepted beat, checks hold while
   // stalled, read address order and outstanding reads, counts done pulses.
   initial begin
      logic       hold_p;
      logic [7:0] pd;
      logic       pl;
      beat_t      e;
      hold_p = 1'b0;
      pd = '0;
      pl = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n || !busy) begin
            hold_p = 1'b0;
            beats  = 0;
            reads  = 0;
         end else begin
            if (hold_p) begin
               check("hold_data", int'(m_if.data), int'(pd));
               check("hold_last", int'(m_if.last), int'(pl));
            end
            hold_p = m_if.valid && !m_if.ready;
            pd = m_if.data;
            pl = m_if.last;
            if (m_if.valid && m_if.ready) begin
               check("beat_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("beat_data", int'(m_if.data), int'(e.d));
                  check("beat_last", int'(m_if.last), int'(e.l));
               end
               beats++;
            end
            if (bram_en) begin
               check("read_addr", int'(bram_addr), reads);
               reads++;
               check("outstanding_le2", int'((reads - beats) <= 2), 1);
            end
            if (transfer_done) begin
               done_cnt++;
               done_cyc = cyc;
            end
         end
      end
   end

   task automatic load_frame(int p);
      int s;
      s = 0;
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(beat_t'{d: pix(p, i), l: (i == N - 1) && !CKS});
         s += int'(pix(p, i));
      end
      if (CKS) exp_q.push_back(beat_t'{d: s[7:0], l: 1'b1});
   endtask

   // start is sampled at the edge after it is raised; c0 = cyc just after it.
   task automatic start_frame(output int c0);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      c0 = cyc;
   endtask

   task automatic wait_done(int prev, int budget);
      int k;
      k = 0;
      while (done_cnt == prev && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", done_cnt - prev, 1);
      repeat (3) @(negedge clk);
      check("done_single", done_cnt - prev, 1);
      check("queue_empty", exp_q.size(), 0);
      check("idle_after", int'(busy), 0);
   endtask

   function automatic int outs();
      return int'({bram_en, bram_addr, m_if.data, m_if.valid, m_if.last, busy, transfer_done});
   endfunction

   initial begin
      int c0;
      int prev;
      int lat;
      int k;

      repeat (3) @(negedge clk);
      check("reset_outputs", outs(), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", int'(busy), 0);

      // Full-rate frame: first read next cycle, first beat in cycle 3,
      // done pulse in cycle NB+2 counted from start.
      pat_sel = 0;
      rdy_mode = 0;
      load_frame(0);
      prev = done_cnt;
      start_frame(c0);
      @(negedge clk);
      check("first_read_en", int'(bram_en), 1);
      check("first_read_addr", int'(bram_addr), 0);
      lat = 1;
      while (!m_if.valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("first_valid_latency", lat, 3);
      wait_done(prev, 4 * NB + 20);
      check("done_cycle", done_cyc - c0, NB + 2);

      // Random back-pressure.
      pat_sel = 1;
      rdy_mode = 1;
      load_frame(1);
      prev = done_cnt;
      start_frame(c0);
      wait_done(prev, 40 * NB + 40);
      rdy_mode = 0;

      // Sink stalled from the start: exactly two reads, then nothing.
      rdy_mode = 2;
      pat_sel = 0;
      load_frame(0);
      prev = done_cnt;
      start_frame(c0);
      repeat (100) @(negedge clk);
      check("stall_reads", reads, 2);
      check("stall_bram_en", int'(bram_en), 0);
      check("stall_valid", int'(m_if.valid), 1);
      check("stall_data", int'(m_if.data), int'(pix(0, 0)));
      rdy_mode = 0;
      wait_done(prev, 4 * NB + 20);

      // start re-pulsed mid-frame is ignored.
      pat_sel = 1;
      rdy_mode = 1;
      load_frame(1);
      prev = done_cnt;
      start_frame(c0);
      k = 0;
      while (beats < 10 && k < 40 * NB) begin
         @(negedge clk);
         k++;
      end
      check("reach_beat10", int'(beats >= 10), 1);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(prev, 40 * NB + 40);
      rdy_mode = 0;

      // Reset mid-frame: outputs drop at once, no done, clean restart.
      pat_sel = 0;
      load_frame(0);
      prev = done_cnt;
      start_frame(c0);
      k = 0;
      while (beats < 12 && k < 4 * NB) begin
         @(negedge clk);
         k++;
      end
      check("reach_beat12", int'(beats >= 12), 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      check("abort_outputs", outs(), 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      check("abort_no_done", done_cnt - prev, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      pat_sel = 2;
      load_frame(2);
      prev = done_cnt;
      start_frame(c0);
      @(negedge clk);
      check("restart_read_en", int'(bram_en), 1);
      check("restart_read_addr", int'(bram_addr), 0);
      wait_done(prev, 4 * NB + 20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
